// File: rtl/bram_stream_reader_pkg.sv
// Shared constants and state encoding for the BRAM stream reader.
// RAM port geometry and the reader FSM states.
package bram_stream_reader_pkg;

  localparam int RAM_ADDR_W = 9;
  localparam int RAM_DATA_W = 8;
  localparam int RAM_RD_LAT = 1;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;

  // Width needed to hold a count of 0..n.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bram_stream_reader_fifo.sv
// Small synchronous FIFO holding read data plus its last flag.
// Push and pop may coincide, including when full.
module bram_rd_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          CLKA,
  input  logic          RSTB,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LASTP = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULLC = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic          full;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == LASTP) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == FULLC);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rp];

  // Pointer and occupancy tracking.
  always_ff @(posedge CLKA) begin
    if (RSTB) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= inc(wp);
      if (do_pop)  rp <= inc(rp);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset since reads are gated by count.
  always_ff @(posedge CLKA) begin
    if (do_push) mem[wp] <= din;
  end

endmodule

// File: rtl/bram_stream_reader.sv
// Walks a BRAM address range and streams the bytes out as valid/ready beats.
// Reads are credit-limited so the output FIFO can never overflow.
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int ADDR_W     = RAM_ADDR_W,
  parameter int DATA_W     = RAM_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLKA,
  input  logic              RSTB,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              ram_en,
  output logic              ram_we,
  output logic              ram_rst,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  localparam int CW = cnt_w(FIFO_DEPTH);
  localparam int OW = CW + 2;
  localparam logic [ADDR_W:0] LEN1 = (ADDR_W + 1)'(1);

  state_t                st;
  logic [ADDR_W:0]       remain;
  logic                  en_last;
  logic                  zdone;
  logic [RAM_RD_LAT-1:0] rv_sr;
  logic [RAM_RD_LAT-1:0] rl_sr;
  logic [CW-1:0]         f_count;
  logic                  f_empty;
  logic [DATA_W:0]       f_dout;
  logic [OW-1:0]         occ;
  logic                  can_issue;
  logic                  hs;
  logic                  fin;

  assign ram_we  = 1'b0;
  assign ram_rst = 1'b0;

  // Credit: buffered beats plus reads still in the RAM pipeline.
  always_comb begin
    occ = OW'(f_count) + OW'(ram_en);
    for (int i = 0; i < RAM_RD_LAT; i++) begin
      occ = occ + OW'(rv_sr[i]);
    end
  end

  assign can_issue = (occ < OW'(FIFO_DEPTH));

  assign m_valid = ~f_empty;
  assign m_data  = f_empty ? '0 : f_dout[DATA_W-1:0];
  assign m_last  = ~f_empty & f_dout[DATA_W];
  assign hs      = m_valid & m_ready;
  assign fin     = (st == ST_DRAIN) & hs & m_last;
  assign done    = fin | zdone;
  assign busy    = (st != ST_IDLE) & ~fin;

  // Command FSM and registered RAM read port.
  always_ff @(posedge CLKA) begin
    if (RSTB) begin
      st       <= ST_IDLE;
      remain   <= '0;
      ram_en   <= 1'b0;
      ram_addr <= '0;
      en_last  <= 1'b0;
      zdone    <= 1'b0;
    end else begin
      ram_en <= 1'b0;
      zdone  <= 1'b0;
      unique case (st)
        ST_IDLE: begin
          if (start) begin
            if (length == '0) begin
              zdone <= 1'b1;
            end else begin
              st       <= ST_ISSUE;
              ram_en   <= 1'b1;
              ram_addr <= base_addr;
              remain   <= length - LEN1;
              en_last  <= (length == LEN1);
            end
          end
        end
        ST_ISSUE: begin
          if (remain == '0) begin
            st <= ST_DRAIN;
          end else if (can_issue) begin
            ram_en   <= 1'b1;
            ram_addr <= ram_addr + ADDR_W'(1);
            remain   <= remain - LEN1;
            en_last  <= (remain == LEN1);
            if (remain == LEN1) st <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (fin) st <= ST_IDLE;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  // Track which RAM output cycles carry data for us, and its last tag.
  always_ff @(posedge CLKA) begin
    if (RSTB) begin
      rv_sr <= '0;
      rl_sr <= '0;
    end else begin
      rv_sr[0] <= ram_en;
      rl_sr[0] <= en_last;
      for (int i = 1; i < RAM_RD_LAT; i++) begin
        rv_sr[i] <= rv_sr[i-1];
        rl_sr[i] <= rl_sr[i-1];
      end
    end
  end

  bram_rd_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .CLKA  (CLKA),
    .RSTB  (RSTB),
    .push  (rv_sr[RAM_RD_LAT-1]),
    .din   ({rl_sr[RAM_RD_LAT-1], ram_dout}),
    .pop   (hs),
    .dout  (f_dout),
    .count (f_count),
    .empty (f_empty)
  );

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: RAM model, reference queue model,
// per-cycle compare process and directed plus random commands.
module tb_bram_stream_reader;

  localparam int AW    = 9;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int NA    = 512;

  logic          CLKA = 1'b0;
  logic          RSTB = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          busy, done, ram_en, ram_we, ram_rst;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dout = '0;
  logic [DW-1:0] m_data;
  logic          m_valid, m_last;
  logic          m_ready = 1'b0;

  logic [7:0] mem [NA];

  always #5 CLKA = ~CLKA;

  bram_stream_reader #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .CLKA      (CLKA),
    .RSTB      (RSTB),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_rst   (ram_rst),
    .ram_addr  (ram_addr),
    .ram_dout  (ram_dout),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last)
  );

  // RAM with one cycle registered read latency
  always @(posedge CLKA) begin
    if (ram_en) ram_dout <= mem[ram_addr];
  end

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Sink ready generator
  int rmode = 0;
  int rpi = 0;
  bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  always @(posedge CLKA) begin
    #1;
    case (rmode)
      0: m_ready = 1'b1;
      1: begin
        m_ready = pat[rpi % 6];
        rpi++;
      end
      default: m_ready = ($urandom_range(0, 2) != 0);
    endcase
  end

  // Reference model state
  logic [7:0]    qd [$];
  bit            ql [$];
  bit            active = 0, zpend = 0, rst_prev = 0, rdy_hold = 0;
  bit            pv = 0, pr = 0, pl = 0;
  logic [7:0]    pdat = '0;
  int            cyc = 0, s_cyc = 0, issued = 0, beats = 0;
  int            cur_len = 0, done_cyc = -1;
  logic [AW-1:0] cur_base = '0;
  int            en_log [$];
  int            bt_log [$];
  logic [7:0]    dt_log [$];
  bit            lt_log [$];
  logic [AW-1:0] ad_log [$];

  // Compare process: checks every cycle against the queue model
  always @(negedge CLKA) begin
    bit            was_active;
    bit            hs;
    bit            fin;
    logic [AW-1:0] ea;
    cyc++;
    was_active = active;
    fin = 0;
    if (rst_prev) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ram_en", ram_en, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_m_data", m_data, 0);
      rst_prev = 0;
    end
    chk("ram_we", ram_we, 0);
    chk("ram_rst", ram_rst, 0);
    if (pv && !pr) begin
      chk("hold_valid", m_valid, 1);
      chk("hold_data", m_data, pdat);
      chk("hold_last", m_last, pl);
    end
    if (m_valid) chk("spurious_valid", qd.size() != 0, 1);
    if (was_active && beats == 0 && cyc <= s_cyc + 3)
      chk("first_valid", m_valid, cyc == s_cyc + 3);
    if (rdy_hold && beats > 0 && qd.size() > 0)
      chk("bubble", m_valid, 1);
    if (ram_en) begin
      chk("extra_issue", active && issued < cur_len, 1);
      ea = cur_base + AW'(issued);
      chk("ram_addr", ram_addr, ea);
      if (issued == 0) chk("first_en", cyc, s_cyc + 1);
      en_log.push_back(cyc - s_cyc);
      ad_log.push_back(ram_addr);
      issued++;
      chk("credit", (issued - beats) <= DEPTH, 1);
    end
    hs = m_valid && m_ready;
    if (hs && qd.size() > 0) begin
      chk("beat_data", m_data, qd[0]);
      chk("beat_last", m_last, ql[0]);
      bt_log.push_back(cyc - s_cyc);
      dt_log.push_back(m_data);
      lt_log.push_back(m_last);
      fin = ql[0];
      void'(qd.pop_front());
      void'(ql.pop_front());
      beats++;
    end
    chk("done", done, fin || zpend);
    if (done) done_cyc = cyc - s_cyc;
    zpend = 0;
    chk("busy", busy, was_active && !fin);
    if (fin) active = 0;
    if (!m_ready) rdy_hold = 0;
    pv = m_valid;
    pr = m_ready;
    pdat = m_data;
    pl = m_last;
    if (RSTB) begin
      qd.delete();
      ql.delete();
      active = 0;
      zpend = 0;
      rst_prev = 1;
      pv = 0;
    end else if (start && !was_active) begin
      s_cyc = cyc;
      issued = 0;
      beats = 0;
      rdy_hold = 1;
      done_cyc = -1;
      en_log.delete();
      bt_log.delete();
      dt_log.delete();
      lt_log.delete();
      ad_log.delete();
      if (length == '0) begin
        zpend = 1;
      end else begin
        active = 1;
        cur_len = int'(length);
        cur_base = base_addr;
        for (int i = 0; i < cur_len; i++) begin
          qd.push_back(mem[AW'(int'(base_addr) + i)]);
          ql.push_back(i == cur_len - 1);
        end
      end
    end
  end

  task automatic step();
    @(posedge CLKA);
    #1;
  endtask

  task automatic start_cmd(input int b, input int l);
    start = 1'b1;
    base_addr = AW'(b);
    length = (AW + 1)'(l);
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (!active && !zpend && qd.size() == 0) begin
        ok = 1;
        break;
      end
      step();
    end
    if (!ok) begin
      nerr++;
      $display("FAIL idle_timeout: got busy want idle");
    end
    step();
  endtask

  function automatic int qi(input int q [$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  initial begin
    for (int i = 0; i < NA; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) mem[16 + i] = 8'hA0 + 8'(i);
    RSTB = 1'b1;
    repeat (3) step();
    RSTB = 1'b0;
    step();

    // basic len=4 with sink always ready
    rmode = 0;
    step();
    start_cmd(16, 4);
    wait_idle(200);
    chk("t1_nen", en_log.size(), 4);
    chk("t1_nbeat", bt_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_en_cyc", qi(en_log, i), i + 1);
      chk("t1_beat_cyc", qi(bt_log, i), i + 3);
      if (i < dt_log.size()) begin
        chk("t1_data", dt_log[i], 8'hA0 + 8'(i));
        chk("t1_last", lt_log[i], i == 3);
      end
    end
    chk("t1_done_cyc", done_cyc, 6);

    // toggling ready, short and longer
    rmode = 1;
    start_cmd(16, 4);
    wait_idle(200);
    chk("t2_nbeat", beats, 4);
    if (dt_log.size() == 4) chk("t2_data3", dt_log[3], 8'hA3);
    start_cmd(100, 20);
    wait_idle(400);
    chk("t2b_nbeat", beats, 20);

    // wrap across the top of the address space
    rmode = 0;
    start_cmd(9'h1FE, 4);
    wait_idle(200);
    chk("t3_n", ad_log.size(), 4);
    if (ad_log.size() == 4) begin
      chk("t3_a0", ad_log[0], 9'h1FE);
      chk("t3_a1", ad_log[1], 9'h1FF);
      chk("t3_a2", ad_log[2], 9'h000);
      chk("t3_a3", ad_log[3], 9'h001);
    end

    // zero length, then start pulsed during an active command
    start_cmd(32, 0);
    wait_idle(20);
    chk("t4_done_cyc", done_cyc, 1);
    chk("t4_nen", en_log.size(), 0);
    start_cmd(48, 6);
    step();
    step();
    start_cmd(200, 3);
    wait_idle(200);
    chk("t4_nbeat", beats, 6);

    // reset in the middle of a len=8 command
    start_cmd(80, 8);
    for (int i = 0; i < 100 && beats < 2; i++) step();
    chk("t5_two_beats", beats >= 2, 1);
    RSTB = 1'b1;
    step();
    RSTB = 1'b0;
    step();
    step();
    start_cmd(96, 2);
    wait_idle(200);
    chk("t5_nbeat", beats, 2);
    chk("t5_done_cyc", done_cyc, 4);

    // full address space with sink always ready
    begin
      bit seen [NA];
      int nseen;
      start_cmd(128, 512);
      wait_idle(1200);
      chk("t6_nbeat", beats, 512);
      chk("t6_span", qi(bt_log, 511) - qi(bt_log, 0), 511);
      nseen = 0;
      foreach (seen[i]) seen[i] = 0;
      foreach (ad_log[i]) begin
        if (!seen[ad_log[i]]) nseen++;
        seen[ad_log[i]] = 1;
      end
      chk("t6_addrs", nseen, 512);
    end

    // random commands with random sink backpressure
    rmode = 2;
    for (int n = 0; n < 25; n++) begin
      start_cmd(int'($urandom_range(0, NA - 1)),
                int'($urandom_range(0, 24)));
      if ($urandom_range(0, 2) == 0) begin
        step();
        start_cmd(int'($urandom_range(0, NA - 1)),
                  int'($urandom_range(1, 5)));
      end
      wait_idle(2000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule
